// File: rtl/fir_pkg.sv
// Shared constants, state encoding and ring-pointer helpers for the FIR MAC controller.
// Output saturation is enabled by defining FIR_OUT_SATURATE_EN (see fir_mac_controller).
package fir_pkg;

    localparam int unsigned LEN     = 100;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned ACC_W   = 40;
    localparam int unsigned Q_SHIFT = 15;
    localparam int unsigned PTR_W   = $clog2(LEN);
    localparam int unsigned K_W     = $clog2(LEN + 1);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(LEN - 1);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(LEN - 1);
    localparam logic [K_W-1:0]   K_END    = K_W'(LEN);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StMac   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } fir_state_e;

    // (newest - k) mod LEN, valid for newest, k in [0, LEN-1]
    function automatic logic [PTR_W-1:0] ring_index(input logic [PTR_W-1:0] newest,
                                                    input logic [PTR_W-1:0] k);
        logic [PTR_W:0] diff;
        diff = {1'b0, newest} - {1'b0, k};
        if (diff[PTR_W]) begin
            diff = diff + (PTR_W + 1)'(LEN);
        end
        return diff[PTR_W-1:0];
    endfunction

endpackage

// File: rtl/fir_sample_buffer.sv
// Circular sample store: one write per accepted sample, combinational read of the
// sample k steps older than the newest entry; whole store clears on reset.
module fir_sample_buffer
    import fir_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [PTR_W-1:0]  i_rd_k,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [LEN];
    logic [PTR_W-1:0]  r_wp;
    logic [PTR_W-1:0]  r_newest;
    logic [PTR_W-1:0]  w_rd_idx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < LEN; i++) begin
                r_mem[i] <= '0;
            end
            r_wp     <= '0;
            r_newest <= '0;
        end else if (i_we) begin
            r_mem[r_wp] <= i_wdata;
            r_newest    <= r_wp;
            r_wp        <= (r_wp == LAST_PTR) ? '0 : r_wp + PTR_W'(1);
        end
    end

    assign w_rd_idx  = ring_index(r_newest, i_rd_k);
    assign o_rd_data = r_mem[w_rd_idx];

endmodule

// File: rtl/fir_mac_controller.sv
// Sequential MAC controller for the LEN-tap FIR: one sample in, LEN taps walked, one sample out.
// Define FIR_OUT_SATURATE_EN to saturate the Q15 output instead of wrapping.
module fir_mac_controller
    import fir_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [PTR_W-1:0]    coef_addr,
    input  logic [DATA_W-1:0]   coef_data,
    output logic [DATA_W-1:0]   mult_a,
    output logic [DATA_W-1:0]   mult_b,
    input  logic [2*DATA_W-1:0] mult_p,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready
);

    fir_state_e        r_state;
    logic [K_W-1:0]    r_k;
    logic [PTR_W-1:0]  r_coef_addr;
    logic [DATA_W-1:0] r_mult_a;
    logic [DATA_W-1:0] r_mult_b;
    logic              r_prod_valid;
    logic [ACC_W-1:0]  r_acc;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;

    logic              w_we;
    logic [DATA_W-1:0] w_rd_data;
    logic [ACC_W-1:0]  w_prod_ext;
    logic [DATA_W-1:0] w_out_q;

    assign w_we       = (r_state == StIdle) && in_valid;
    assign w_prod_ext = {{(ACC_W - 2*DATA_W){mult_p[2*DATA_W-1]}}, mult_p};

    fir_sample_buffer u_buf (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_we      (w_we),
        .i_wdata   (in_data),
        .i_rd_k    (PTR_W'(r_k)),
        .o_rd_data (w_rd_data)
    );

    // acc >>> Q_SHIFT keeps bits [Q_SHIFT +: DATA_W]; the bits above decide overflow
    always_comb begin
        w_out_q = r_acc[Q_SHIFT +: DATA_W];
`ifdef FIR_OUT_SATURATE_EN
        if (!(&r_acc[ACC_W-1:Q_SHIFT+DATA_W-1]) && (|r_acc[ACC_W-1:Q_SHIFT+DATA_W-1])) begin
            w_out_q = r_acc[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_k          <= '0;
            r_coef_addr  <= '0;
            r_mult_a     <= '0;
            r_mult_b     <= '0;
            r_prod_valid <= 1'b0;
            r_acc        <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
        end else begin
            if (r_prod_valid) begin
                r_acc <= r_acc + w_prod_ext;
            end
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_acc       <= '0;
                        r_k         <= '0;
                        r_coef_addr <= '0;
                        r_state     <= StMac;
                    end
                end
                StMac: begin
                    // One extra cycle after the last issue lets product LEN-1 land in acc
                    if (r_k == K_END) begin
                        r_prod_valid <= 1'b0;
                        r_state      <= StDrain;
                    end else begin
                        r_mult_a     <= w_rd_data;
                        r_mult_b     <= coef_data;
                        r_coef_addr  <= (r_k == K_LAST) ? '0 : PTR_W'(r_k + K_W'(1));
                        r_prod_valid <= 1'b1;
                        r_k          <= r_k + K_W'(1);
                    end
                end
                StDrain: begin
                    r_out_data  <= w_out_q;
                    r_out_valid <= 1'b1;
                    r_state     <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign in_ready  = (r_state == StIdle) && !rst;
    assign coef_addr = r_coef_addr;
    assign mult_a    = r_mult_a;
    assign mult_b    = r_mult_b;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_fir_mac_controller.sv
// Directed self-checking bench for fir_mac_controller with a behavioural coefficient ROM
// and combinational signed multiplier; honours FIR_OUT_SATURATE_EN for expected values.
module tb_fir_mac_controller;
    import fir_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic [DATA_W-1:0]   in_data;
    logic                in_valid;
    logic                in_ready;
    logic [PTR_W-1:0]    coef_addr;
    logic [DATA_W-1:0]   coef_data;
    logic [DATA_W-1:0]   mult_a;
    logic [DATA_W-1:0]   mult_b;
    logic [2*DATA_W-1:0] mult_p;
    logic [DATA_W-1:0]   out_data;
    logic                out_valid;
    logic                out_ready;

    logic [DATA_W-1:0]   rom [LEN];

    int checks     = 0;
    int errors     = 0;
    int timeouts   = 0;
    int ready_leak = 0;
    int lat_bad    = 0;

    always #5 clk = ~clk;

    assign coef_data = (int'(coef_addr) < int'(LEN)) ? rom[coef_addr] : '0;
    assign mult_p    = 32'($signed(mult_a) * $signed(mult_b));

    fir_mac_controller dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .mult_a    (mult_a),
        .mult_b    (mult_b),
        .mult_p    (mult_p),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_rom_const(input logic [DATA_W-1:0] v);
        for (int i = 0; i < LEN; i++) rom[i] = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Accept x, then wait (bounded) until out_valid; leaves out_ready low.
    task automatic run_sample(input logic [DATA_W-1:0] x, output logic [DATA_W-1:0] y,
                              output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) timeouts++;
        in_data = x; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 300) begin
            if (in_ready) ready_leak++;
            @(negedge clk);
            lat++;
        end
        if (!out_valid) timeouts++;
        y = out_data;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] y;
        logic [DATA_W-1:0] exp_v;
        int lat;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        for (int i = 0; i < LEN; i++) rom[i] = 16'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_mult_a",    32'(mult_a),    32'd0);
        check("rst_mult_b",    32'(mult_b),    32'd0);
        check("rst_coef_addr", 32'(coef_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Impulse through ramp ROM h[k]=k: output n is -n, then 0 once the impulse leaves
        for (int n = 0; n <= 100; n++) begin
            run_sample((n == 0) ? 16'h8000 : 16'h0000, y, lat);
            exp_v = (n == 100) ? 16'h0000 : 16'(-n);
            check($sformatf("impulse[%0d]", n), 32'(y), 32'(exp_v));
            if (n == 0) check("latency_first", 32'(lat), 32'd102);
            if (lat != 102) lat_bad++;
            handshake();
        end
        check("latency_all", 32'(lat_bad), 32'd0);
        check("busy_in_ready_low", 32'(ready_leak), 32'd0);

        // Constant 0x4000 into h=0x4000: n * 0x2000 per output
        do_reset();
        set_rom_const(16'h4000);
        for (int n = 1; n <= 100; n++) begin
            run_sample(16'h4000, y, lat);
            if (n == 1) check("const[1]", 32'(y), 32'h2000);
            if (n == 2) check("const[2]", 32'(y), 32'h4000);
            if (n == 3) check("const[3]", 32'(y), 32'h6000);
`ifdef FIR_OUT_SATURATE_EN
            if (n == 4)   check("const[4]",   32'(y), 32'h7FFF);
            if (n == 100) check("const[100]", 32'(y), 32'h7FFF);
`else
            if (n == 4)   check("const[4]",   32'(y), 32'h8000);
            if (n == 100) check("const[100]", 32'(y), 32'h8000);
`endif
            handshake();
        end

        // Negative 0xC000 into h=0x4000: -n * 0x2000 per output
        do_reset();
        set_rom_const(16'h4000);
        for (int n = 1; n <= 100; n++) begin
            run_sample(16'hC000, y, lat);
            if (n == 1) check("neg[1]", 32'(y), 32'hE000);
            if (n == 4) check("neg[4]", 32'(y), 32'h8000);
`ifdef FIR_OUT_SATURATE_EN
            if (n == 5) check("neg[5]", 32'(y), 32'h8000);
`else
            if (n == 5) check("neg[5]", 32'(y), 32'h6000);
`endif
            if (n == 100) check("neg[100]", 32'(y), 32'h8000);
            handshake();
        end

        // Backpressure: output held, new samples refused while out_ready is low
        do_reset();
        set_rom_const(16'h4000);
        run_sample(16'h4000, y, lat);
        check("bp_first", 32'(y), 32'h2000);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 16'h1234;
            @(negedge clk);
            check($sformatf("bp_data[%0d]", i),     32'(out_data),  32'h2000);
            check($sformatf("bp_valid[%0d]", i),    32'(out_valid), 32'd1);
            check($sformatf("bp_in_ready[%0d]", i), 32'(in_ready),  32'd0);
        end
        handshake();
        in_valid = 1'b0;
        check("bp_idle_in_ready", 32'(in_ready),  32'd1);
        check("bp_idle_valid",    32'(out_valid), 32'd0);
        // Only 0x4000 (tap 1) may contribute; a stray 0x1234 write would shift the window
        run_sample(16'h0000, y, lat);
        check("bp_next", 32'(y), 32'h2000);
        handshake();

        // Reset in the middle of MAC clears outputs and the whole buffer
        do_reset();
        set_rom_const(16'h4000);
        for (int n = 1; n <= 3; n++) begin
            run_sample(16'h4000, y, lat);
            handshake();
        end
        check("pre_rst_out", 32'(y), 32'h6000);
        @(negedge clk);
        in_data = 16'h4000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (50) @(negedge clk);
        check("mid_mac_busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_in_ready",  32'(in_ready),  32'd0);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_out_data",  32'(out_data),  32'd0);
        check("mrst_mult_a",    32'(mult_a),    32'd0);
        check("mrst_mult_b",    32'(mult_b),    32'd0);
        check("mrst_coef_addr", 32'(coef_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("mrst_idle", 32'(in_ready), 32'd1);
        run_sample(16'h4000, y, lat);
        check("post_rst_out", 32'(y), 32'h2000);
        handshake();

        check("timeouts", 32'(timeouts), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
